// File: rtl/qtr_sense_pkg.sv
// qtr_sense_pkg: shared state encodings and result constants for the QTR sensor timing engine
// No ports; imported by qtr_sense.
package qtr_sense_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHARGE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;
    localparam int VALUE_W = 8;
    localparam logic [VALUE_W-1:0] TICKS_SAT = 8'd255;
endpackage

// File: rtl/qtr_sense_us_tick_gen.sv
// us_tick_gen: period prescaler emitting a one-cycle tick every PERIOD enabled clocks
// Ports: clk, reset_n (async active-low), clr (sync clear), en (count enable), tick (wrap pulse).
module us_tick_gen #(
    parameter int PERIOD = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int W = $clog2(PERIOD + 1);
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(PERIOD - 1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/qtr_sense.sv
// qtr_sense: charges a QTR-1RC node, times its decay in TICK_US units, returns a saturating 8-bit value
// Ports: clk, reset_n (async active-low), en (start request), value/valid (result and update strobe),
//        busy (not idle), qtr_out_en/qtr_out_sig (pad drive), qtr_in_sig (async pin readback),
//        qtr_ctrl (IR emitter enable).
module qtr_sense import qtr_sense_pkg::*; #(
    parameter int CLK_FREQUENCY = 60_000_000,
    parameter int CHARGE_US     = 10,
    parameter int TICK_US       = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    output logic [VALUE_W-1:0] value,
    output logic               valid,
    output logic               busy,
    output logic               qtr_out_en,
    output logic               qtr_out_sig,
    input  logic               qtr_in_sig,
    output logic               qtr_ctrl
);
    // Scale via 100 kHz units so any legal clock divides exactly.
    localparam int CHARGE_CYCLES = CLK_FREQUENCY / 100_000 * CHARGE_US / 10;
    localparam int TICK_CYCLES   = CLK_FREQUENCY / 100_000 * TICK_US / 10;
    localparam int CW = $clog2((CHARGE_CYCLES > SETTLE_CYCLES ? CHARGE_CYCLES : SETTLE_CYCLES) + 1);
    state_t state, state_nxt;
    logic [1:0] sync;
    logic in_s, ready, tick, charge_done, settled;
    logic [CW-1:0] cnt;
    logic [VALUE_W-1:0] ticks;
    assign in_s = sync[1];
    assign charge_done = cnt == CW'(CHARGE_CYCLES - 1);
    assign settled = cnt >= CW'(SETTLE_CYCLES);
    // Synchroniser resets high so a stale low cannot end the first measurement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= 2'b11;
        else sync <= {sync[0], qtr_in_sig};
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        qtr_ctrl    = 1'b0;
        qtr_out_en  = 1'b0;
        qtr_out_sig = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (en && ready) state_nxt = CHARGE;
            end
            CHARGE: begin
                qtr_ctrl    = 1'b1;
                qtr_out_en  = 1'b1;
                qtr_out_sig = 1'b1;
                if (charge_done) state_nxt = MEASURE;
            end
            MEASURE: begin
                qtr_ctrl = 1'b1;
                if (settled && (!in_s || ticks == TICKS_SAT)) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    us_tick_gen #(.PERIOD(TICK_CYCLES)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (state != MEASURE),
        .en      (state == MEASURE),
        .tick    (tick)
    );
    // ready delays the first accepted en to the second edge after reset release.
    // cnt counts CHARGE clocks, then saturates at SETTLE_CYCLES in MEASURE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready <= 1'b0;
            cnt   <= '0;
            ticks <= '0;
            value <= '0;
            valid <= 1'b0;
        end else begin
            ready <= 1'b1;
            valid <= state == DONE;
            if (state == DONE) value <= ticks;
            if (state == IDLE || state_nxt != state) cnt <= '0;
            else if (state == CHARGE || !settled) cnt <= cnt + 1'b1;
            if (state == IDLE) ticks <= '0;
            else if (tick && ticks != TICKS_SAT) ticks <= ticks + 1'b1;
        end
    end
endmodule

// File: tb/tb_qtr_sense.sv
// tb_qtr_sense: self-checking bench for qtr_sense at 1 MHz (10-cycle charge, 10-cycle tick, 4-cycle settle)
module tb_qtr_sense;
    logic clk = 1'b0;
    logic reset_n, en, qtr_in_sig;
    logic [7:0] value;
    logic valid, busy, qtr_out_en, qtr_out_sig, qtr_ctrl;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    int e;

    qtr_sense #(.CLK_FREQUENCY(1_000_000)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .value       (value),
        .valid       (valid),
        .busy        (busy),
        .qtr_out_en  (qtr_out_en),
        .qtr_out_sig (qtr_out_sig),
        .qtr_in_sig  (qtr_in_sig),
        .qtr_ctrl    (qtr_ctrl)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every valid pulse must match the oldest expected value.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid value=%0d required=no valid", value);
            end else begin
                e = exp_q.pop_front();
                if (int'(value) !== e) begin
                    failures++;
                    $display("FAIL value got=%0d required=%0d", value, e);
                end
            end
        end
    end

    task automatic test_reset;
        reset_n = 1'b0;
        en = 1'b0;
        qtr_in_sig = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({value, valid, busy, qtr_out_en, qtr_out_sig, qtr_ctrl} !== 13'd0) begin
            failures++;
            $display("FAIL reset_state got=%h required=0", {value, valid, busy, qtr_out_en, qtr_out_sig, qtr_ctrl});
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // drop: clocks after MEASURE entry at which the pin falls; -1 never, -2 low throughout.
    task automatic measure(input string name, input int drop, input int exp_val, input int exp_m,
                           input bit pulses, input bit pre);
        int k, n_oen, n_ctrl, n_idle, n;
        qtr_in_sig = (drop == -2) ? 1'b0 : 1'b1;
        en = 1'b1;
        exp_q.push_back(exp_val);
        if (pre) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL %s early_accept busy=%b required=0", name, busy);
            end
        end
        @(negedge clk);
        en = 1'b0;
        k = cyc;
        checks++;
        if ({busy, qtr_ctrl, qtr_out_en, qtr_out_sig} !== 4'b1111) begin
            failures++;
            $display("FAIL %s charge_entry got=%b required=1111", name, {busy, qtr_ctrl, qtr_out_en, qtr_out_sig});
        end
        n_oen = 0;
        n_ctrl = 0;
        n_idle = 0;
        n = 0;
        while (valid !== 1'b1 && n < 4000) begin
            n_oen += int'(qtr_out_en);
            n_ctrl += int'(qtr_ctrl);
            n_idle += int'(!busy);
            if (drop >= 0 && cyc == k + 10 + drop) qtr_in_sig = 1'b0;
            en = pulses && (cyc == k + 5 || cyc == k + 30);
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        checks++;
        if (valid !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout valid=%b required=1", name, valid);
        end
        checks++;
        if (cyc !== k + 11 + exp_m) begin
            failures++;
            $display("FAIL %s latency got=%0d required=%0d", name, cyc - k, 11 + exp_m);
        end
        checks++;
        if (n_oen !== 10) begin
            failures++;
            $display("FAIL %s out_en_cycles got=%0d required=10", name, n_oen);
        end
        checks++;
        if (n_ctrl !== 10 + exp_m) begin
            failures++;
            $display("FAIL %s ctrl_cycles got=%0d required=%0d", name, n_ctrl, 10 + exp_m);
        end
        checks++;
        if (n_idle !== 0) begin
            failures++;
            $display("FAIL %s busy_drop got=%0d required=0", name, n_idle);
        end
        @(negedge clk);
        checks++;
        if ({valid, busy, qtr_ctrl} !== 3'b000) begin
            failures++;
            $display("FAIL %s after_valid got=%b required=000", name, {valid, busy, qtr_ctrl});
        end
    endtask

    task automatic test_single;
        measure("single", 35, 3, 38, 1'b0, 1'b0);
    endtask

    task automatic test_saturate;
        measure("saturate", -1, 255, 2551, 1'b0, 1'b0);
    endtask

    task automatic test_low_settle;
        measure("low_settle", -2, 0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_en;
        measure("ignore_en", 35, 3, 38, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int k;
        qtr_in_sig = 1'b1;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        k = cyc;
        while (cyc < k + 60) @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({value, valid, busy, qtr_out_en, qtr_out_sig, qtr_ctrl} !== 13'd0) begin
            failures++;
            $display("FAIL reset_mid outputs got=%h required=0", {value, valid, busy, qtr_out_en, qtr_out_sig, qtr_ctrl});
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid busy_in_reset got=%b required=0", busy);
        end
        reset_n = 1'b1;
        measure("reset_recover", 25, 2, 28, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back;
        int k, nv, n;
        qtr_in_sig = 1'b1;
        en = 1'b1;
        repeat (3) exp_q.push_back(1);
        @(negedge clk);
        k = cyc;
        nv = 0;
        n = 0;
        while (nv < 3 && n < 300) begin
            if ((cyc - k) % 30 == 25) qtr_in_sig = 1'b0;
            if ((cyc - k) % 30 == 29) qtr_in_sig = 1'b1;
            if (valid === 1'b1) begin
                checks++;
                if (cyc !== k + 29 + 30 * nv) begin
                    failures++;
                    $display("FAIL back_to_back spacing pulse=%0d got=%0d required=%0d", nv, cyc - k, 29 + 30 * nv);
                end
                nv++;
                if (nv == 3) en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        en = 1'b0;
        checks++;
        if (nv !== 3) begin
            failures++;
            $display("FAIL back_to_back pulses got=%0d required=3", nv);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back stop busy=%b required=0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_saturate();
        test_low_settle();
        test_ignore_en();
        test_reset_mid();
        test_back_to_back();
        repeat (40) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_results got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
